sakebi_tx_frame_arbiter: RTL and testbench

Frame-level arbiter and sequencer in front of the RMII transmit path. It shares the single AXI-Stream TX input between two frame sources, s0 and s1, with round-robin arbitration at frame granularity. It zero-pads runt frames to the Ethernet minimum and enforces an inter-frame gap before the next grant. It runs entirely in the AXI-Stream clock domain, upstream of the RMII TX block's async FIFO.

---
 rtl/sakebi_pkg.sv | 26 ++
 rtl/sakebi_tx_frame_arbiter.sv | 123 ++++++++++++
 tb/tb_sakebi_tx_frame_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sakebi_pkg.sv
// Shared types and constants for the sakebi Ethernet TX path.
// Holds the arbiter state encoding and the round-robin selector.
package sakebi_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] PAD  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StPass = PASS,
    StPad  = PAD,
    StGap  = GAP
  } state_e;

  localparam int unsigned ETH_MIN_FRAME  = 60;
  localparam int unsigned ETH_IFG_CYCLES = 96;

  // Two-way round robin: on a tie the requester that was not served last wins.
  function automatic logic rr_pick(input logic last_served, input logic [1:0] req);
    if (&req) return ~last_served;
    return req[1] & ~req[0];
  endfunction

endpackage

// File: rtl/sakebi_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for two AXI-Stream TX sources.
// Pads runt frames to the Ethernet minimum and inserts an inter-frame gap.
module sakebi_tx_frame_arbiter
  import sakebi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MIN_FRAME  = ETH_MIN_FRAME,
  parameter int unsigned IFG_CYCLES = ETH_IFG_CYCLES
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESETn,
  input  logic                  i_s0_axis_TVALID,
  output logic                  o_s0_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_s0_axis_TDATA,
  input  logic                  i_s0_axis_TLAST,
  input  logic                  i_s1_axis_TVALID,
  output logic                  o_s1_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_s1_axis_TDATA,
  input  logic                  i_s1_axis_TLAST,
  output logic                  o_m_axis_TVALID,
  input  logic                  i_m_axis_TREADY,
  output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
  output logic                  o_m_axis_TLAST,
  output logic [1:0]            o_grant,
  output logic                  o_busy
);

  localparam int unsigned CntW = $clog2(MIN_FRAME + 1);
  localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(MIN_FRAME - 1);
  localparam logic [CntW-1:0] MinCnt  = CntW'(MIN_FRAME);
  localparam logic [GapW-1:0] GapLast = GapW'(IFG_CYCLES - 1);

  state_e          state_q;
  logic            owner_q;   // 0 = s0, 1 = s1
  logic            rr_ptr_q;
  logic [CntW-1:0] byte_cnt_q;
  logic [GapW-1:0] gap_cnt_q;

  logic [1:0]            req;
  logic                  src_valid;
  logic                  src_last;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  m_hs;
  logic                  at_min;

  assign req       = {i_s1_axis_TVALID, i_s0_axis_TVALID};
  assign src_valid = owner_q ? i_s1_axis_TVALID : i_s0_axis_TVALID;
  assign src_last  = owner_q ? i_s1_axis_TLAST  : i_s0_axis_TLAST;
  assign src_data  = owner_q ? i_s1_axis_TDATA  : i_s0_axis_TDATA;
  assign m_hs      = o_m_axis_TVALID & i_m_axis_TREADY;
  // byte_cnt_q counts bytes already sent, so the current beat is byte byte_cnt_q+1.
  assign at_min    = byte_cnt_q >= LastIdx;

  always_comb begin
    o_m_axis_TVALID  = 1'b0;
    o_m_axis_TDATA   = '0;
    o_m_axis_TLAST   = 1'b0;
    o_s0_axis_TREADY = 1'b0;
    o_s1_axis_TREADY = 1'b0;
    o_grant          = 2'b00;
    o_busy           = state_q != StIdle;
    unique case (state_q)
      StPass: begin
        o_m_axis_TVALID  = src_valid;
        o_m_axis_TDATA   = src_data;
        o_m_axis_TLAST   = src_last & at_min;
        o_s0_axis_TREADY = ~owner_q & i_m_axis_TREADY;
        o_s1_axis_TREADY = owner_q & i_m_axis_TREADY;
        o_grant          = owner_q ? 2'b10 : 2'b01;
      end
      StPad: begin
        o_m_axis_TVALID = 1'b1;
        o_m_axis_TLAST  = byte_cnt_q == LastIdx;
        o_grant         = owner_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b1;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          byte_cnt_q <= '0;
          gap_cnt_q  <= '0;
          if (|req) begin
            owner_q <= rr_pick(rr_ptr_q, req);
            state_q <= StPass;
          end
        end
        StPass: begin
          if (m_hs) begin
            if (byte_cnt_q != MinCnt) byte_cnt_q <= byte_cnt_q + 1'b1;
            if (src_last) state_q <= at_min ? StGap : StPad;
          end
        end
        StPad: begin
          if (m_hs) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == LastIdx) state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q  <= StIdle;
            rr_ptr_q <= owner_q;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sakebi_tx_frame_arbiter.sv
// Self-checking bench for sakebi_tx_frame_arbiter: frame table plus
// contention and mid-frame reset sequences, checked through a beat scoreboard.
module tb_sakebi_tx_frame_arbiter;
  import sakebi_pkg::*;

  localparam int unsigned Ifg  = ETH_IFG_CYCLES;
  localparam int unsigned MinF = ETH_MIN_FRAME;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s0_valid = 1'b0, s0_last = 1'b0, s0_ready;
  logic [7:0] s0_data = 8'h0;
  logic       s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
  logic [7:0] s1_data = 8'h0;
  logic       m_valid, m_last;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic [1:0] grant;
  logic       busy;

  always #5 clk = ~clk;

  sakebi_tx_frame_arbiter #(
    .DATA_WIDTH(8),
    .MIN_FRAME (MinF),
    .IFG_CYCLES(Ifg)
  ) dut (
    .i_axis_ACLK     (clk),
    .i_axis_ARESETn  (rst_n),
    .i_s0_axis_TVALID(s0_valid),
    .o_s0_axis_TREADY(s0_ready),
    .i_s0_axis_TDATA (s0_data),
    .i_s0_axis_TLAST (s0_last),
    .i_s1_axis_TVALID(s1_valid),
    .o_s1_axis_TREADY(s1_ready),
    .i_s1_axis_TDATA (s1_data),
    .i_s1_axis_TLAST (s1_last),
    .o_m_axis_TVALID (m_valid),
    .i_m_axis_TREADY (m_ready),
    .o_m_axis_TDATA  (m_data),
    .o_m_axis_TLAST  (m_last),
    .o_grant         (grant),
    .o_busy          (busy)
  );

  typedef struct packed {
    logic       pad;
    logic [1:0] grant;
    logic       last;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    bit         src;
    int         len;
    logic [7:0] d0;
    logic [7:0] step;
    bit         bp;
    int         exp_len;
    logic [1:0] exp_grant;
  } vec_t;

  exp_t       exp_q[$];
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];

  int n_vec = 0, n_fail = 0;
  int cyc = 0, frames_done = 0, beat_cnt = 0, last_len = 0, last_cyc = 0;
  bit in_frame = 0, have_prev = 0, bp_en = 0, prev_v = 0, prev_hs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic add_src(input bit src, input int len, input logic [7:0] d0,
                         input logic [7:0] step);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      d = d0 + 8'(i) * step;
      if (src) src_q1.push_back({i == len - 1, d});
      else     src_q0.push_back({i == len - 1, d});
    end
  endtask

  // Reference model of the emitted frame: payload, then zero padding up to MinF.
  task automatic add_exp(input int len, input logic [7:0] d0, input logic [7:0] step,
                         input logic [1:0] g);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.pad   = 1'b0;
      e.grant = g;
      e.last  = (i == len - 1) && (len >= MinF);
      e.data  = d0 + 8'(i) * step;
      exp_q.push_back(e);
    end
    for (int i = len; i < MinF; i++) begin
      e.pad   = 1'b1;
      e.grant = g;
      e.last  = (i == MinF - 1);
      e.data  = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (frames_done < target) check("frame_timeout", frames_done, target);
  endtask

  task automatic check_busy_gap();
    int n = 0;
    for (int i = 0; i < Ifg + 5; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("busy_after_last", n, Ifg);
  endtask

  // Sources and sink monitor: sample at negedge, update inputs 1 after posedge.
  always begin
    logic hs0, hs1, mhs;
    exp_t e;
    @(negedge clk);
    cyc++;
    hs0 = s0_valid & s0_ready;
    hs1 = s1_valid & s1_ready;
    mhs = m_valid & m_ready;
    if (!rst_n) begin
      in_frame  = 0;
      have_prev = 0;
      prev_v    = 0;
      prev_hs   = 0;
    end else begin
      if (prev_v && !prev_hs) check("tvalid_held", m_valid, 1);
      if (mhs) begin
        if (!in_frame) begin
          if (have_prev) check("ifg_spacing", (cyc - last_cyc) >= int'(Ifg + 2), 1);
          in_frame = 1;
          beat_cnt = 0;
        end
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_data, 9'h100);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
          check("beat_grant", grant, e.grant);
          if (e.pad) check("src_ready_in_pad", {s1_ready, s0_ready}, 0);
        end
        if (m_last) begin
          in_frame  = 0;
          have_prev = 1;
          last_cyc  = cyc;
          last_len  = beat_cnt;
          frames_done++;
        end
      end
      prev_v  = m_valid;
      prev_hs = mhs;
    end
    @(posedge clk);
    #1;
    if (hs0 && src_q0.size() != 0) void'(src_q0.pop_front());
    if (hs1 && src_q1.size() != 0) void'(src_q1.pop_front());
    s0_valid = src_q0.size() != 0;
    {s0_last, s0_data} = s0_valid ? src_q0[0] : 9'h0;
    s1_valid = src_q1.size() != 0;
    {s1_last, s1_data} = s1_valid ? src_q1[0] : 9'h0;
    m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    vec_t tv[7];
    int   base;
    int   n;
    tv[0] = '{0,  64, 8'h00, 8'h01, 0,  64, 2'b01};
    tv[1] = '{1,  20, 8'hA5, 8'h00, 0,  60, 2'b10};
    tv[2] = '{0,  60, 8'h10, 8'h03, 0,  60, 2'b01};
    tv[3] = '{1, 100, 8'h00, 8'h07, 1, 100, 2'b10};
    tv[4] = '{0,   1, 8'h5A, 8'h00, 0,  60, 2'b01};
    tv[5] = '{1,  59, 8'hC0, 8'h01, 0,  60, 2'b10};
    tv[6] = '{0,  61, 8'h33, 8'h05, 0,  61, 2'b01};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {s0_ready, s1_ready, m_valid, m_data, m_last, grant, busy}, 0);
    rst_n = 1'b1;

    // Both sources hold three frames from reset: strict alternation, s0 first.
    base = frames_done;
    for (int k = 0; k < 3; k++) begin
      add_src(0, 61 + k, 8'(8'h10 * k), 8'h01);
      add_src(1, 61 + k, 8'(8'h80 + 8'h10 * k), 8'h01);
    end
    for (int k = 0; k < 3; k++) begin
      add_exp(61 + k, 8'(8'h10 * k), 8'h01, 2'b01);
      add_exp(61 + k, 8'(8'h80 + 8'h10 * k), 8'h01, 2'b10);
    end
    wait_frames(base + 6, 3000);
    check("contention_drained", exp_q.size(), 0);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);

    foreach (tv[k]) begin
      base  = frames_done;
      bp_en = tv[k].bp;
      add_src(tv[k].src, tv[k].len, tv[k].d0, tv[k].step);
      add_exp(tv[k].len, tv[k].d0, tv[k].step, tv[k].exp_grant);
      wait_frames(base + 1, 2000);
      bp_en = 0;
      check("frame_len", last_len, tv[k].exp_len);
      check_busy_gap();
      check("frame_drained", exp_q.size(), 0);
    end

    // Last served was s0; a reset mid s1 frame must restore s0 priority.
    add_src(1, 30, 8'h80, 8'h01);
    add_exp(30, 8'h80, 8'h01, 2'b10);
    n = 0;
    while (!(in_frame && grant == 2'b10 && beat_cnt == 10) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) check("reset_point_timeout", 0, 1);
    #3 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {s0_ready, s1_ready, m_valid, m_data, m_last, grant, busy}, 0);
    src_q1.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("held_reset_outputs", {s0_ready, s1_ready, m_valid, m_data, m_last, grant, busy}, 0);
    rst_n = 1'b1;
    base  = frames_done;
    add_src(0, 62, 8'h20, 8'h02);
    add_src(1, 62, 8'h90, 8'h02);
    add_exp(62, 8'h20, 8'h02, 2'b01);
    add_exp(62, 8'h90, 8'h02, 2'b10);
    wait_frames(base + 2, 1000);
    check("post_reset_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
